// File: rtl/serial_rx_pkg.sv
// Shared types and elaboration helpers for the serial deserializer.
package serial_rx_pkg;

  typedef enum logic [1:0] {StIdle, StActive, StDone} rx_state_e;

  function automatic int unsigned calc_beats(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned width, input int unsigned lanes);
    return $clog2(width / lanes + 1);
  endfunction

  function automatic bit lanes_divide_width(input int unsigned width, input int unsigned lanes);
    return (lanes != 0) && ((width % lanes) == 0);
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial pin and parallel word bundle for serial_deserializer.
interface serial_deserializer_if
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 1
);
  localparam int unsigned CntW = calc_cnt_w(WIDTH, LANES);

  logic             sclk;
  logic             cs_n;
  logic [LANES-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [CntW-1:0]  bit_count;
  logic             frame_err;
  logic             overrun;

  modport master (
    output sclk, cs_n, data_in,
    input  data_out, data_valid, busy, bit_count, frame_err, overrun
  );

  modport slave (
    input  sclk, cs_n, data_in,
    output data_out, data_valid, busy, bit_count, frame_err, overrun
  );
endinterface

// File: rtl/sclk_edge_sync.sv
// Optional 2-flop input synchronisers (SERIAL_DESER_SYNC_EN) and sclk rising-edge detector.
module sclk_edge_sync #(
  parameter int unsigned LANES = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sclk_i,
  input  logic             cs_n_i,
  input  logic [LANES-1:0] data_i,
  output logic             cs_n_o,
  output logic [LANES-1:0] data_o,
  output logic             sclk_rise_o
);

  logic sclk_s;
  logic sclk_prev_q;

`ifdef SERIAL_DESER_SYNC_EN
  logic [1:0]       sclk_sync_q;
  logic [1:0]       cs_n_sync_q;
  logic [LANES-1:0] data_s1_q;
  logic [LANES-1:0] data_s2_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_sync_q <= 2'b11;
      cs_n_sync_q <= 2'b11;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      cs_n_sync_q <= {cs_n_sync_q[0], cs_n_i};
      data_s1_q   <= data_i;
      data_s2_q   <= data_s1_q;
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign cs_n_o = cs_n_sync_q[1];
  assign data_o = data_s2_q;
`else
  assign sclk_s = sclk_i;
  assign cs_n_o = cs_n_i;
  assign data_o = data_i;
`endif

  // Resets high so an sclk held high through reset is not seen as an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_rise_o = sclk_s & ~sclk_prev_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: shifts LANES bits per sclk rising edge while cs_n is low.
// Build option SERIAL_DESER_SYNC_EN adds 2-flop input synchronisers (see sclk_edge_sync).
module serial_deserializer
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LANES     = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input logic                 clk,
  input logic                 reset,
  serial_deserializer_if.slave rx_io
);

  localparam int unsigned BEATS = calc_beats(WIDTH, LANES);
  localparam int unsigned CntW  = calc_cnt_w(WIDTH, LANES);
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  if (!lanes_divide_width(WIDTH, LANES)) begin : gen_bad_cfg
    $error("serial_deserializer: WIDTH must be a nonzero multiple of LANES");
  end

  logic             cs_n;
  logic [LANES-1:0] din;
  logic             sclk_rise;

  sclk_edge_sync #(
    .LANES(LANES)
  ) u_edge_sync (
    .clk_i      (clk),
    .reset_i    (reset),
    .sclk_i     (rx_io.sclk),
    .cs_n_i     (rx_io.cs_n),
    .data_i     (rx_io.data_in),
    .cs_n_o     (cs_n),
    .data_o     (din),
    .sclk_rise_o(sclk_rise)
  );

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             overrun_q, overrun_d;
  logic             busy;

  // Frame start clears the shifter, so a beat captured in IDLE shifts into zero.
  logic [WIDTH-1:0]       shift_base;
  logic [WIDTH+LANES-1:0] wide;
  logic [WIDTH-1:0]       shifted;
  logic [LANES-1:0]       unused_dropped;

  always_comb begin
    shift_base = (state_q == StIdle) ? '0 : shreg_q;
    if (MSB_FIRST != 0) begin
      wide           = {shift_base, din};
      shifted        = wide[WIDTH-1:0];
      unused_dropped = wide[WIDTH+LANES-1:WIDTH];
    end else begin
      wide           = {din, shift_base};
      shifted        = wide[WIDTH+LANES-1:LANES];
      unused_dropped = wide[LANES-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!cs_n) state_d = (sclk_rise && (BEATS == 1)) ? StDone : StActive;
      end
      StActive: begin
        // cs_n rising wins over a coincident edge.
        if (cs_n) begin
          state_d = StIdle;
        end else if (sclk_rise && (cnt_q == LastCnt)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (cs_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    overrun_d  = overrun_q;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!cs_n) begin
          shreg_d   = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          if (sclk_rise) begin
            shreg_d = shifted;
            cnt_d   = CntW'(1);
            if (BEATS == 1) begin
              data_out_d = shifted;
              valid_d    = 1'b1;
            end
          end
        end
      end
      StActive: begin
        busy = 1'b1;
        if (cs_n) begin
          ferr_d = 1'b1;
        end else if (sclk_rise) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            data_out_d = shifted;
            valid_d    = 1'b1;
          end
        end
      end
      StDone: begin
        if (sclk_rise) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_io.data_out   = data_out_q;
  assign rx_io.data_valid = valid_q;
  assign rx_io.busy       = busy;
  assign rx_io.bit_count  = cnt_q;
  assign rx_io.frame_err  = ferr_q;
  assign rx_io.overrun    = overrun_q;

endmodule
